rib_timer: RTL and testbench



---
 rtl/rib_timer.sv | 155 +++++++++++++++
 tb/tb_rib_timer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_timer.sv
// RIB-bus memory-mapped timer: prescaled up-counter, compare match, one-shot/periodic, W1C pending flag.
// Build option: define TIMER_PRESCALER_EN to include the PRESC register and prescaler counter.
module rib_timer #(
   parameter int INT_W   = 8,
   parameter int INT_BIT = 0,
   parameter int PRESC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_req_i,
   input  logic             wr_en_i,
   input  logic [31:0]      wr_addr_i,
   input  logic [31:0]      wr_data_i,
   input  logic             rd_req_i,
   input  logic [31:0]      rd_addr_i,
   output logic [31:0]      rd_data_o,
   output logic [INT_W-1:0] int_flag_o
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_PRESC  = 3'd1;
   localparam logic [2:0] A_COUNT  = 3'd2;
   localparam logic [2:0] A_CMP    = 3'd3;
   localparam logic [2:0] A_STATUS = 3'd4;

   state_e      state_q, state_d;
   logic        ie_q, ie_d, per_q, per_d;
   logic [31:0] count_q, count_d, cmp_q, cmp_d;
   logic        pend_q, pend_d, irq_q, irq_d;
   logic        wr_hit, wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
   logic        run, tick, match;
   logic [31:0] presc_rd;
   logic        unused_addr_bits;

   assign unused_addr_bits = &{1'b0, wr_addr_i[31:5], wr_addr_i[1:0],
                               rd_addr_i[31:5], rd_addr_i[1:0]};

   assign wr_hit    = wr_req_i & wr_en_i;
   assign wr_ctrl   = wr_hit && (wr_addr_i[4:2] == A_CTRL);
   assign wr_presc  = wr_hit && (wr_addr_i[4:2] == A_PRESC);
   assign wr_count  = wr_hit && (wr_addr_i[4:2] == A_COUNT);
   assign wr_cmp    = wr_hit && (wr_addr_i[4:2] == A_CMP);
   assign wr_status = wr_hit && (wr_addr_i[4:2] == A_STATUS);

`ifdef TIMER_PRESCALER_EN
   logic [PRESC_W-1:0] presc_q, presc_d, psc_cnt_q, psc_cnt_d;

   always_comb begin
      presc_d   = presc_q;
      psc_cnt_d = psc_cnt_q + 1'b1;
      if (wr_presc) presc_d = wr_data_i[PRESC_W-1:0];
      if (wr_ctrl || wr_presc || !run || (psc_cnt_q == presc_q)) psc_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         psc_cnt_q <= '0;
      end else begin
         presc_q   <= presc_d;
         psc_cnt_q <= psc_cnt_d;
      end
   end

   assign tick     = run && (psc_cnt_q == presc_q);
   assign presc_rd = 32'(presc_q);
`else
   logic unused_presc_wr;
   assign unused_presc_wr = wr_presc;
   assign tick            = run;
   assign presc_rd        = '0;
`endif

   // Compare always uses the CMP value held before any same-cycle write.
   assign match = tick && (count_q == cmp_q);

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state; a CTRL write overrides a one-shot stop.
   always_comb begin
      state_d = state_q;
      if (wr_ctrl)               state_d = wr_data_i[0] ? S_RUN : S_IDLE;
      else if (match && !per_q)  state_d = S_IDLE;
   end

   // FSM: outputs
   always_comb begin
      run = (state_q == S_RUN);
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      ie_d    = ie_q;
      per_d   = per_q;
      cmp_d   = cmp_q;
      count_d = count_q;
      pend_d  = pend_q;
      if (wr_ctrl) begin
         ie_d  = wr_data_i[1];
         per_d = wr_data_i[2];
      end
      if (wr_cmp) cmp_d = wr_data_i;
      if (wr_count)   count_d = wr_data_i;
      else if (match) count_d = per_q ? 32'd0 : count_q;
      else if (tick)  count_d = count_q + 32'd1;
      if (match)                          pend_d = 1'b1;
      else if (wr_status && wr_data_i[0]) pend_d = 1'b0;
      irq_d = pend_q & ie_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie_q    <= 1'b0;
         per_q   <= 1'b0;
         cmp_q   <= '0;
         count_q <= '0;
         pend_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         ie_q    <= ie_d;
         per_q   <= per_d;
         cmp_q   <= cmp_d;
         count_q <= count_d;
         pend_q  <= pend_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      if (rd_req_i) begin
         case (rd_addr_i[4:2])
            A_CTRL:   rd_data_o = {29'd0, per_q, ie_q, run};
            A_PRESC:  rd_data_o = presc_rd;
            A_COUNT:  rd_data_o = count_q;
            A_CMP:    rd_data_o = cmp_q;
            A_STATUS: rd_data_o = {31'd0, pend_q};
            default:  rd_data_o = '0;
         endcase
      end
   end

   always_comb begin
      int_flag_o          = '0;
      int_flag_o[INT_BIT] = irq_q;
   end

endmodule

// File: tb/tb_rib_timer.sv
// Self-checking bench for rib_timer: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_rib_timer;

`ifdef TIMER_PRESCALER_EN
   localparam bit HAS_PSC = 1'b1;
`else
   localparam bit HAS_PSC = 1'b0;
`endif

   logic        clk, rst_n;
   logic        wr_req_i, wr_en_i, rd_req_i;
   logic [31:0] wr_addr_i, wr_data_i, rd_addr_i, rd_data_o;
   logic [7:0]  int_flag_o;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   bit          m_en, m_ie, m_per, m_pend, m_irq;
   logic [15:0] m_presc, m_psc;
   logic [31:0] m_count, m_cmp;

   rib_timer #(.INT_W(8), .INT_BIT(0), .PRESC_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_req_i(wr_req_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
      .int_flag_o(int_flag_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_en = 0; m_ie = 0; m_per = 0; m_pend = 0; m_irq = 0;
      m_presc = '0; m_psc = '0; m_count = '0; m_cmp = '0;
   endtask

   function automatic bit model_tick();
      return m_en && (!HAS_PSC || (m_psc == m_presc));
   endfunction

   function automatic bit model_match_next();
      return model_tick() && (m_count == m_cmp);
   endfunction

   // One clock edge of the timer's register-level rules, given this cycle's write.
   task automatic model_step(input bit w, input logic [31:0] a, input logic [31:0] d);
      bit tick, match;
      logic [2:0] r;
      r     = a[4:2];
      tick  = model_tick();
      match = tick && (m_count == m_cmp);
      m_irq = m_pend && m_ie;
      if (HAS_PSC) begin
         if ((w && (r == 3'd0 || r == 3'd1)) || !m_en || m_psc == m_presc) m_psc = '0;
         else m_psc = m_psc + 16'd1;
      end
      if (w && r == 3'd2)  m_count = d;
      else if (match)      m_count = m_per ? 32'd0 : m_count;
      else if (tick)       m_count = m_count + 32'd1;
      if (match)                        m_pend = 1;
      else if (w && r == 3'd4 && d[0])  m_pend = 0;
      if (w && r == 3'd0)        m_en = d[0];
      else if (match && !m_per)  m_en = 0;
      if (w && r == 3'd0) begin m_ie = d[1]; m_per = d[2]; end
      if (w && r == 3'd3) m_cmp = d;
      if (HAS_PSC && w && r == 3'd1) m_presc = d[15:0];
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      case (a[4:2])
         3'd0:    return {29'd0, m_per, m_ie, m_en};
         3'd1:    return {16'd0, m_presc};
         3'd2:    return m_count;
         3'd3:    return m_cmp;
         3'd4:    return {31'd0, m_pend};
         default: return 32'd0;
      endcase
   endfunction

   // Drive one bus cycle; inputs settle 1ns after the edge, model advances with the edge.
   task automatic cyc(input bit req, input bit en, input logic [31:0] a, input logic [31:0] d);
      wr_req_i = req; wr_en_i = en; wr_addr_i = a; wr_data_i = d;
      @(posedge clk);
      model_step(req & en, a, d);
      #1;
      wr_req_i = 0; wr_en_i = 0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cyc(1, 1, a, d);
   endtask

   task automatic idle();
      cyc(0, 0, 32'd0, 32'd0);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      rd_req_i = 1; rd_addr_i = a;
      #0.2;
      v = rd_data_o;
      rd_req_i = 0;
      #0.1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 0;
      model_reset();
      #2;
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         rd(32'(i * 4), v);
         n_checks++;
         if (v !== 32'd0) $display("FAIL reset_rd[%0d] got %h expected %h", i * 4, v, 32'd0);
         else n_pass++;
      end
      n_checks++;
      if (int_flag_o !== 8'h00) $display("FAIL reset_irq got %h expected %h", int_flag_o, 8'h00);
      else n_pass++;
      n_checks++;
      if (rd_data_o !== 32'd0) $display("FAIL rd_idle got %h expected %h", rd_data_o, 32'd0);
      else n_pass++;
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      apply_reset();
      wr(32'h04, 32'd0);
      wr(32'h0C, 32'd5);
      wr(32'h00, 32'h3);
      for (int k = 1; k <= 5; k++) begin
         idle();
         rd(32'h08, v);
         n_checks++;
         if (v !== 32'(k)) $display("FAIL oneshot_count got %0d expected %0d", v, k);
         else n_pass++;
      end
      idle();
      rd(32'h10, v);
      n_checks++;
      if (v !== 32'd1) $display("FAIL oneshot_pend got %h expected %h", v, 32'd1);
      else n_pass++;
      n_checks++;
      if (int_flag_o !== 8'h00) $display("FAIL oneshot_irq_lag got %h expected %h", int_flag_o, 8'h00);
      else n_pass++;
      idle();
      n_checks++;
      if (int_flag_o !== 8'h01) $display("FAIL oneshot_irq got %h expected %h", int_flag_o, 8'h01);
      else n_pass++;
      rd(32'h00, v);
      n_checks++;
      if (v !== 32'h2) $display("FAIL oneshot_ctrl got %h expected %h", v, 32'h2);
      else n_pass++;
      rd(32'h08, v);
      n_checks++;
      if (v !== 32'd5) $display("FAIL oneshot_hold got %0d expected %0d", v, 5);
      else n_pass++;
   endtask

   task automatic test_periodic();
      logic [31:0] v;
      apply_reset();
      wr(32'h04, 32'd3);
      wr(32'h0C, 32'd2);
      wr(32'h00, 32'h7);
      for (int k = 1; k <= 30; k++) begin
         idle();
         if (k == 4) begin
            rd(32'h08, v);
            n_checks++;
            if (v !== 32'd1) $display("FAIL periodic_count4 got %0d expected %0d", v, 1);
            else n_pass++;
         end
         rd(32'h08, v);
         n_checks++;
         if (v !== model_read(32'h08)) $display("FAIL periodic_count got %0d expected %0d", v, model_read(32'h08));
         else n_pass++;
         rd(32'h10, v);
         n_checks++;
         if (v !== model_read(32'h10)) $display("FAIL periodic_pend got %h expected %h", v, model_read(32'h10));
         else n_pass++;
      end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] v;
      bit done;
      done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         if (!model_match_next()) begin wr(32'h10, 32'h1); done = 1; end
         else idle();
      end
      done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         if (model_match_next()) begin wr(32'h10, 32'h1); done = 1; end
         else idle();
      end
      n_checks++;
      if (!done) $display("FAIL w1c_wait got %0d expected %0d", 0, 1);
      else n_pass++;
      rd(32'h10, v);
      n_checks++;
      if (v !== 32'd1) $display("FAIL w1c_set_wins got %h expected %h", v, 32'd1);
      else n_pass++;
      wr(32'h10, 32'h1);
      rd(32'h10, v);
      n_checks++;
      if (v !== 32'd0) $display("FAIL w1c_clear got %h expected %h", v, 32'd0);
      else n_pass++;
      n_checks++;
      if (int_flag_o !== 8'h01) $display("FAIL w1c_irq_lag got %h expected %h", int_flag_o, 8'h01);
      else n_pass++;
      idle();
      n_checks++;
      if (int_flag_o !== 8'h00) $display("FAIL w1c_irq_drop got %h expected %h", int_flag_o, 8'h00);
      else n_pass++;
   endtask

   task automatic test_wrap_and_collision();
      logic [31:0] v;
      apply_reset();
      wr(32'h08, 32'hFFFF_FFFF);
      wr(32'h0C, 32'h10);
      wr(32'h00, 32'h1);
      idle();
      rd(32'h08, v);
      n_checks++;
      if (v !== 32'd0) $display("FAIL wrap_count got %h expected %h", v, 32'd0);
      else n_pass++;
      rd(32'h10, v);
      n_checks++;
      if (v !== 32'd0) $display("FAIL wrap_pend got %h expected %h", v, 32'd0);
      else n_pass++;
      wr(32'h08, 32'h1234);
      rd(32'h08, v);
      n_checks++;
      if (v !== 32'h1234) $display("FAIL count_write_wins got %h expected %h", v, 32'h1234);
      else n_pass++;
      idle();
      rd(32'h08, v);
      n_checks++;
      if (v !== 32'h1235) $display("FAIL count_after_write got %h expected %h", v, 32'h1235);
      else n_pass++;
   endtask

   task automatic test_reset_midrun();
      logic [31:0] v;
      apply_reset();
      wr(32'h0C, 32'd0);
      wr(32'h00, 32'h7);
      idle(); idle(); idle();
      n_checks++;
      if (int_flag_o !== 8'h01) $display("FAIL midrun_irq_before got %h expected %h", int_flag_o, 8'h01);
      else n_pass++;
      #2;
      rst_n = 0;
      model_reset();
      #0.5;
      n_checks++;
      if (int_flag_o !== 8'h00) $display("FAIL midrun_irq_async got %h expected %h", int_flag_o, 8'h00);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         rd(32'(i * 4), v);
         n_checks++;
         if (v !== 32'd0) $display("FAIL midrun_rd[%0d] got %h expected %h", i * 4, v, 32'd0);
         else n_pass++;
      end
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_presc_option();
      logic [31:0] v;
      apply_reset();
      wr(32'h04, 32'd7);
      rd(32'h04, v);
      n_checks++;
      if (v !== (HAS_PSC ? 32'd7 : 32'd0)) $display("FAIL presc_rd got %h expected %h", v, HAS_PSC ? 32'd7 : 32'd0);
      else n_pass++;
      wr(32'h0C, 32'd100);
      wr(32'h00, 32'h1);
      idle();
      rd(32'h08, v);
      n_checks++;
      if (v !== (HAS_PSC ? 32'd0 : 32'd1)) $display("FAIL presc_tick got %0d expected %0d", v, HAS_PSC ? 0 : 1);
      else n_pass++;
      for (int k = 0; k < 16; k++) begin
         idle();
         rd(32'h08, v);
         n_checks++;
         if (v !== model_read(32'h08)) $display("FAIL presc_count got %0d expected %0d", v, model_read(32'h08));
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v, a, d;
      logic [2:0]  sel;
      bit          req, en;
      apply_reset();
      wr(32'h00, 32'h7);
      for (int k = 0; k < 400; k++) begin
         sel = 3'($urandom_range(0, 7));
         a   = {$urandom() & 32'hFFFF_FFE0} | {27'd0, sel, 2'b00} | 32'($urandom_range(0, 3));
         case (sel)
            3'd0:    d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : (32'($urandom_range(0, 7)) | 32'h1);
            3'd1:    d = 32'($urandom_range(0, 3));
            3'd2,
            3'd3:    d = 32'($urandom_range(0, 6));
            3'd4:    d = 32'($urandom_range(0, 1));
            default: d = $urandom();
         endcase
         req = ($urandom_range(0, 3) == 0);
         en  = ($urandom_range(0, 5) != 0);
         cyc(req, en, a, d);
         a = 32'($urandom_range(0, 7) * 4);
         rd(a, v);
         n_checks++;
         if (v !== model_read(a)) $display("FAIL rand_rd[%0d] addr %h got %h expected %h", k, a, v, model_read(a));
         else n_pass++;
         n_checks++;
         if (int_flag_o !== {7'd0, m_irq}) $display("FAIL rand_irq[%0d] got %h expected %h", k, int_flag_o, {7'd0, m_irq});
         else n_pass++;
      end
   endtask

   initial begin
      rst_n = 1; wr_req_i = 0; wr_en_i = 0; rd_req_i = 0;
      wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0;
      model_reset();
      test_reset();
      test_oneshot();
      test_periodic();
      test_w1c_collision();
      test_wrap_and_collision();
      test_reset_midrun();
      test_presc_option();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got %0d expected %0d", n_checks, -1);
      $fatal(1, "bench timeout");
   end

endmodule
